// File: rtl/seg_reduce_unit_pkg.sv
// Shared sizing constants and lane types for the segmented row reducer.
// Module parameters take their defaults from here; a bench may override them.
package seg_reduce_unit_pkg;

    localparam int SRU_N   = 16;
    localparam int SRU_W   = 8;
    localparam int SRU_LGN = $clog2(SRU_N);

    typedef logic [SRU_W-1:0] data_t;

    typedef struct packed {
        data_t              data;
        logic               split;
        logic [SRU_LGN-1:0] idx;
    } lane_t;

endpackage

// File: rtl/seg_scan_stage.sv
// One Kogge-Stone level of the segmented inclusive scan.
// Carries the beat's sideband (valid, split, idx, last) alongside the sums.
module seg_scan_stage
    import seg_reduce_unit_pkg::*;
#(
    parameter int N    = SRU_N,
    parameter int W    = SRU_W,
    parameter int LGN  = $clog2(N),
    parameter int DIST = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    input  logic [N*W-1:0]     in_data,
    input  logic [N-1:0]       in_flag,
    input  logic [N-1:0]       in_split,
    input  logic [N*LGN-1:0]   in_idx,
    input  logic               in_last,
    output logic               out_valid,
    output logic [N*W-1:0]     out_data,
    output logic [N-1:0]       out_flag,
    output logic [N-1:0]       out_split,
    output logic [N*LGN-1:0]   out_idx,
    output logic               out_last
);

    logic [N*W-1:0]   sum_c;
    logic [N-1:0]     flag_c;

    logic             valid_q, valid_d;
    logic [N*W-1:0]   data_q,  data_d;
    logic [N-1:0]     flag_q,  flag_d;
    logic [N-1:0]     split_q, split_d;
    logic [N*LGN-1:0] idx_q,   idx_d;
    logic             last_q,  last_d;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            if (gi >= DIST) begin : g_comb
                // A segment start inside (gi-DIST, gi] blocks the lower partial sum.
                assign sum_c[gi*W +: W] = in_flag[gi] ? in_data[gi*W +: W]
                                        : in_data[gi*W +: W] + in_data[(gi-DIST)*W +: W];
                assign flag_c[gi]       = in_flag[gi] | in_flag[gi-DIST];
            end else begin : g_pass
                assign sum_c[gi*W +: W] = in_data[gi*W +: W];
                assign flag_c[gi]       = in_flag[gi];
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        flag_d  = flag_q;
        split_d = split_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (en) begin
            valid_d = in_valid;
            data_d  = sum_c;
            flag_d  = flag_c;
            split_d = in_split;
            idx_d   = in_idx;
            last_d  = in_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flag_q  <= '0;
            split_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            split_q <= split_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_flag  = flag_q;
    assign out_split = split_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: rtl/seg_reduce_unit.sv
// Pipelined segmented reducer: input register, LGN scan levels, then halo
// resolution and scatter into the per-tile accumulation row.
module seg_reduce_unit
    import seg_reduce_unit_pkg::*;
#(
    parameter int N   = SRU_N,
    parameter int W   = SRU_W,
    parameter int LGN = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic [N-1:0]       in_split,
    input  logic [N*LGN-1:0]   in_idx,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*W-1:0]     out_data,
    output logic [31:0]        latency,
    output logic [31:0]        num_el
);

    logic en;

    logic             s0_valid_q, s0_valid_d;
    logic [N*W-1:0]   s0_data_q,  s0_data_d;
    logic [N-1:0]     s0_split_q, s0_split_d;
    logic [N*LGN-1:0] s0_idx_q,   s0_idx_d;
    logic             s0_last_q,  s0_last_d;

    logic             sc_valid [LGN+1];
    logic [N*W-1:0]   sc_data  [LGN+1];
    logic [N-1:0]     sc_flag  [LGN+1];
    logic [N-1:0]     sc_split [LGN+1];
    logic [N*LGN-1:0] sc_idx   [LGN+1];
    logic             sc_last  [LGN+1];

    logic [W-1:0] resolved [N];
    logic [W-1:0] acc_new  [N];

    logic [W-1:0] acc_q      [N];
    logic [W-1:0] acc_d      [N];
    logic [W-1:0] out_data_q [N];
    logic [W-1:0] out_data_d [N];
    logic [W-1:0] halo_q, halo_d;
    logic         out_valid_q, out_valid_d;

    // A full output register with no taker freezes the whole pipe.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_data_d  = s0_data_q;
        s0_split_d = s0_split_q;
        s0_idx_d   = s0_idx_q;
        s0_last_d  = s0_last_q;
        if (en) begin
            s0_valid_d = in_valid;
            s0_data_d  = in_data;
            s0_split_d = in_split;
            s0_idx_d   = in_idx;
            s0_last_d  = in_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_split_q <= '0;
            s0_idx_q   <= '0;
            s0_last_q  <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_data_q  <= s0_data_d;
            s0_split_q <= s0_split_d;
            s0_idx_q   <= s0_idx_d;
            s0_last_q  <= s0_last_d;
        end
    end

    // Lane i opens a segment when lane i-1 closed one.
    assign sc_valid[0] = s0_valid_q;
    assign sc_data[0]  = s0_data_q;
    assign sc_flag[0]  = {s0_split_q[N-2:0], 1'b0};
    assign sc_split[0] = s0_split_q;
    assign sc_idx[0]   = s0_idx_q;
    assign sc_last[0]  = s0_last_q;

    genvar gi;
    generate
        for (gi = 0; gi < LGN; gi++) begin : g_scan
            seg_scan_stage #(
                .N    (N),
                .W    (W),
                .LGN  (LGN),
                .DIST (1 << gi)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .en        (en),
                .in_valid  (sc_valid[gi]),
                .in_data   (sc_data[gi]),
                .in_flag   (sc_flag[gi]),
                .in_split  (sc_split[gi]),
                .in_idx    (sc_idx[gi]),
                .in_last   (sc_last[gi]),
                .out_valid (sc_valid[gi+1]),
                .out_data  (sc_data[gi+1]),
                .out_flag  (sc_flag[gi+1]),
                .out_split (sc_split[gi+1]),
                .out_idx   (sc_idx[gi+1]),
                .out_last  (sc_last[gi+1])
            );
        end

        for (gi = 0; gi < N; gi++) begin : g_out
            assign out_data[gi*W +: W] = out_data_q[gi];
        end
    endgenerate

    // After the scan, a clear flag means the lane still belongs to the segment
    // left open by the previous beat, so it picks up the halo.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            resolved[i] = sc_flag[LGN][i] ? sc_data[LGN][i*W +: W]
                        : sc_data[LGN][i*W +: W] + halo_q;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc_new[i] = acc_q[i];
        end
        for (int i = 0; i < N; i++) begin
            if (sc_split[LGN][i]) begin
                acc_new[sc_idx[LGN][i*LGN +: LGN]] = resolved[i];
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        halo_d      = halo_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (sc_valid[LGN]) begin
                if (sc_last[LGN]) begin
                    out_data_d  = acc_new;
                    out_valid_d = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        acc_d[i] = '0;
                    end
                    halo_d = '0;
                end else begin
                    acc_d  = acc_new;
                    halo_d = sc_split[LGN][N-1] ? '0 : resolved[N-1];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i]      <= '0;
                out_data_q[i] <= '0;
            end
            halo_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            halo_q      <= halo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign latency   = 32'(LGN + 2);
    assign num_el    = 32'(N);

endmodule

// File: tb/tb_seg_reduce_unit.sv
// Directed bench for seg_reduce_unit at N=4, W=8: a table of single-beat tiles
// plus hand-written halo, backpressure, open-tail and reset sequences.
module tb_seg_reduce_unit;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LGN = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_split;
    logic [N*LGN-1:0] in_idx;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_data;
    logic [31:0]      latency;
    logic [31:0]      num_el;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seg_reduce_unit #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_split  (in_split),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .latency   (latency),
        .num_el    (num_el)
    );

    typedef struct {
        string            name;
        logic [N*W-1:0]   data;
        logic [N-1:0]     split;
        logic [N*LGN-1:0] idx;
        logic [N*W-1:0]   exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [N*W-1:0] d, input logic [N-1:0] sp,
                             input logic [N*LGN-1:0] ix, input logic lst);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_split = sp;
        in_idx   = ix;
        in_last  = lst;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", t);
        end else begin
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checks the tile, lets it transfer.
    task automatic expect_tile(input string name, input logic [N*W-1:0] exp, output int waits);
        waits = 0;
        while (!out_valid && waits < 40) begin
            @(negedge clock);
            waits++;
        end
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk(name, 64'(out_data), 64'(exp));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        //             name        data {l3,l2,l1,l0}           split    idx {l3,l2,l1,l0}          expected {o3,o2,o1,o0}
        vecs[0] = '{"single",   {8'd4,8'd3,8'd2,8'd1},       4'b1010, {2'd1,2'd0,2'd0,2'd0}, {8'd0,8'd0,8'd7,8'd3}};
        vecs[1] = '{"wrap",     {8'd0,8'd0,8'd100,8'd200},   4'b0010, {2'd0,2'd0,2'd0,2'd0}, {8'd0,8'd0,8'd0,8'd44}};
        vecs[2] = '{"all_split",{8'd40,8'd30,8'd20,8'd10},   4'b1111, {2'd0,2'd1,2'd2,2'd3}, {8'd10,8'd20,8'd30,8'd40}};
        vecs[3] = '{"collide",  {8'd4,8'd3,8'd2,8'd1},       4'b1111, {2'd2,2'd2,2'd2,2'd2}, {8'd0,8'd4,8'd0,8'd0}};
        vecs[4] = '{"one_seg",  {8'd6,8'd7,8'd8,8'd9},       4'b1000, {2'd1,2'd0,2'd0,2'd0}, {8'd0,8'd0,8'd30,8'd0}};
        vecs[5] = '{"ovf",      {8'd255,8'd255,8'd255,8'd255},4'b1000,{2'd0,2'd0,2'd0,2'd0}, {8'd0,8'd0,8'd0,8'd252}};
        vecs[6] = '{"tail_drop",{8'd8,8'd7,8'd6,8'd5},       4'b0101, {2'd0,2'd3,2'd0,2'd3}, {8'd13,8'd0,8'd0,8'd0}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_split  = '0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("latency_port", 64'(latency), 64'd4);
        chk("num_el_port", 64'(num_el), 64'd4);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 7; i++) begin
            send_beat(vecs[i].data, vecs[i].split, vecs[i].idx, 1'b1);
            expect_tile(vecs[i].name, vecs[i].exp, w);
            chk({vecs[i].name, "_latency"}, 64'(w + 1), 64'(LGN + 2));
        end

        // Halo carried from a split-free beat into the first segment of the next.
        send_beat({8'd1,8'd1,8'd1,8'd1}, 4'b0000, '0, 1'b0);
        send_beat({8'd2,8'd2,8'd2,8'd2}, 4'b1001, {2'd3,2'd0,2'd0,2'd2}, 1'b1);
        expect_tile("halo", {8'd6,8'd6,8'd0,8'd0}, w);

        // Open tail on a last beat must not leak into the next tile.
        send_beat({8'd5,8'd5,8'd5,8'd5}, 4'b0000, '0, 1'b1);
        send_beat({8'd7,8'd7,8'd7,8'd7}, 4'b0001, '0, 1'b1);
        expect_tile("tail_t1", '0, w);
        expect_tile("tail_t2", {8'd0,8'd0,8'd0,8'd7}, w);
        chk("tail_t2_b2b", 64'(w), 64'd0);

        // Backpressure: four tiles in flight, consumer stalled.
        out_ready = 1'b0;
        send_beat({8'd1,8'd1,8'd1,8'd1}, 4'b1000, {2'd0,2'd0,2'd0,2'd0}, 1'b1);
        send_beat({8'd2,8'd2,8'd2,8'd2}, 4'b1000, {2'd1,2'd0,2'd0,2'd0}, 1'b1);
        send_beat({8'd3,8'd3,8'd3,8'd3}, 4'b1000, {2'd2,2'd0,2'd0,2'd0}, 1'b1);
        send_beat({8'd4,8'd4,8'd4,8'd4}, 4'b1000, {2'd3,2'd0,2'd0,2'd0}, 1'b1);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_data", 64'(out_data), 64'h00000004);
        repeat (5) @(negedge clock);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_data", 64'(out_data), 64'h00000004);
        out_ready = 1'b1;
        expect_tile("bp_t1", {8'd0,8'd0,8'd0,8'd4}, w);
        expect_tile("bp_t2", {8'd0,8'd0,8'd8,8'd0}, w);
        chk("bp_t2_b2b", 64'(w), 64'd0);
        expect_tile("bp_t3", {8'd0,8'd12,8'd0,8'd0}, w);
        chk("bp_t3_b2b", 64'(w), 64'd0);
        expect_tile("bp_t4", {8'd16,8'd0,8'd0,8'd0}, w);
        chk("bp_t4_b2b", 64'(w), 64'd0);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset with a halo already built and another halo beat in flight.
        send_beat({8'd1,8'd1,8'd1,8'd1}, 4'b0000, '0, 1'b0);
        send_beat({8'd1,8'd1,8'd1,8'd1}, 4'b0000, '0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("post_rst_quiet", 64'(out_valid), 64'd0);
        send_beat(vecs[0].data, vecs[0].split, vecs[0].idx, 1'b1);
        expect_tile("post_rst_single", vecs[0].exp, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_reduce_unit.md
Name: seg_reduce_unit

Overview:
- Parametrised, pipelined successor of the single-beat segmented reducer.
- Reduces a stream of N-lane beats of multiplied partial products into per-row sums, using segment-end flags (split) and a destination index per lane.
- Carries an open trailing segment across beats. Delivers one completed N-entry output row per tile over a valid/ready handshake.
- Sits between the PE multiplier array and the SpMM output buffer.

Parameters:
- N, 16, lanes per beat and output entries per tile (power of two, >=2).
- W, 8, data width; all arithmetic is modulo 2^W.
- LGN, $clog2(N), index width and number of scan stages (derived).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  N x W  products, lane 0 first
- in_split  in  N  1 = lane closes a segment
- in_idx  in  N x LGN  output slot for a closing lane
- in_last  in  1  final beat of the tile
- out_valid  out  1  out_data holds a completed tile
- out_ready  in  1  consumer accepts the tile
- out_data  out  N x W  reduced row sums
- latency  out  32  constant LGN+2
- num_el  out  32  constant N

Behaviour:
- Reset: in_ready=1, out_valid=0, out_data=0, halo=0, pipeline valids=0, accumulation buffer=0. Reset mid-tile discards all in-flight beats and the halo.
- Stall: en = !(out_valid && !out_ready); in_ready = en. When en=0, every register holds.
- Stage 0: register the accepted beat with its valid, split, idx and last.
- Stages 1..LGN: Kogge-Stone segmented inclusive scan.
  - Segment boundary: lane i starts a new segment when split[i-1]=1.
  - Stage s combines lane i with lane i-2^(s-1) only if no segment start lies in (i-2^(s-1), i].
  - Flag and sum are carried together per stage.
- Final stage (LGN+1), halo resolution:
  - Lanes 0..first split lane (inclusive) add halo. If the beat has no split, every lane adds halo.
  - New halo: tail sum after the last split, plus the old halo if the beat has no split. It becomes 0 when split[N-1]=1 or last=1.
  - For each lane with split=1, write the resolved sum into acc[idx]. If two lanes write the same idx, the higher lane wins. Later beats overwrite earlier ones.
- Tile completion: a last beat at the final stage loads out_data from acc merged with that beat's writes, sets out_valid=1, and clears acc and halo.
  - Slots never written read 0.
  - An open tail on a last beat is discarded.
- Handshake: out_valid drops on out_valid && out_ready. If a new tile completes in that same cycle, out_data reloads and out_valid stays 1.
- Latency: accepted last beat to out_valid = LGN+2 cycles when unstalled. Full throughput is one beat per cycle.
- Invalid beats (bubbles) flow through without touching acc or halo.

Decomposition:
- Shared package: data_t (W-bit), N, W, LGN constants, plus a lane bundle struct {data, split, idx}.
- One sub-module, seg_scan_stage: one Kogge-Stone level, parametrised by distance, with a registered output and enable.

Test Plan (N=4, W=8 unless stated):
- Single beat: data {1,2,3,4}, split {0,1,0,1}, idx {-,0,-,1}, last=1 -> out_data {3,7,0,0}; out_valid 4 cycles after accept.
- Halo: beat A {1,1,1,1}, split 0000, last=0; beat B {2,2,2,2}, split {1,0,0,1}, idx {2,-,-,3}, last=1 -> out_data[2]=6, out_data[3]=6, others 0.
- Wrap: data {200,100,0,0}, split {0,1,0,0}, idx 0, last=1 -> out_data[0]=44.
- Backpressure: hold out_ready=0 while out_valid=1, with three more tiles offered -> in_ready=0 and pipeline frozen. Release -> tiles delivered in order with exact values and no loss.
- Open tail at last, then new tile: tile 1 {5,5,5,5}, split 0000, last=1 -> all zeros. Tile 2 {7,..}, split {1,0,0,0}, idx 0 -> out_data[0]=7, not 27.
- Reset mid-tile: reset after halo beat A -> out_valid=0. A following single-beat tile shows no halo contamination.
